// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared types and constants for the sequential ALU
//
// Purpose: opcode and FSM state enums, default datapath width and the bit
//          positions of the registered flag vector used by alu_seq.
// Ports:   none (package).
package alu_seq_pkg;

   localparam int ALU_WIDTH_DEF = 16;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_XOR = 3'd4,
      ALU_SLL = 3'd5,
      ALU_SRL = 3'd6,
      ALU_MUL = 3'd7
   } alu_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } alu_state_e;

   // Flags are kept in one registered vector so they always update together.
   localparam int FLAG_EQUAL    = 0;
   localparam int FLAG_CARRY    = 1;
   localparam int FLAG_OVERFLOW = 2;
   localparam int FLAG_W        = 3;

endpackage

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - iterative unsigned shift-add multiplier
//
// Purpose: multiplies a by b, one partial product per clock, WIDTH iterations.
// Ports:   clk, reset_n   clock and asynchronous active-low reset
//          start          load operands and begin iterating
//          a, b           multiplicand and multiplier (sampled on start)
//          done           high during the last iteration
//          product        full 2*WIDTH product, valid while done is high
module alu_mul_seq #(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int CW = $clog2(WIDTH);

   logic               running;
   logic [CW-1:0]      count;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;
   logic [2*WIDTH-1:0] sum;

   // The product is taken from the adder output so the final partial product
   // is included in the same cycle that done is raised.
   assign sum     = acc + (mplier[0] ? mcand : '0);
   assign product = sum;
   assign done    = running & (count == CW'(WIDTH - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         running <= 1'b0;
         count   <= '0;
         acc     <= '0;
         mcand   <= '0;
         mplier  <= '0;
      end else if (start) begin
         running <= 1'b1;
         count   <= '0;
         acc     <= '0;
         mcand   <= {{WIDTH{1'b0}}, a};
         mplier  <= b;
      end else if (running) begin
         acc     <= sum;
         mcand   <= mcand << 1;
         mplier  <= mplier >> 1;
         count   <= count + 1'b1;
         if (done) begin
            running <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked ALU with registered result, flags and iterative multiply
//
// Purpose: accepts one operation per valid/ready handshake, registers the
//          result and flags, and holds them until the consumer takes them.
// Ports:   clk, reset_n          clock and asynchronous active-low reset
//          in_valid, in_ready    operation handshake
//          op, inputa, inputb    opcode and operands (inputb = shift amount)
//          out_valid, out_ready  result handshake
//          out                   registered result
//          zero                  out == 0
//          equal, carry, overflow registered flags
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] inputa,
   input  logic [WIDTH-1:0] inputb,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             zero,
   output logic             equal,
   output logic             carry,
   output logic             overflow
);

   localparam int SHW = $clog2(WIDTH);

   alu_state_e         state, state_nx;
   logic               accept;
   logic               is_mul;
   logic               start_mul;
   logic               load_alu;
   logic               load_mul;
   logic               mul_done;
   logic [2*WIDTH-1:0] mul_product;

   logic [WIDTH:0]     add_w;
   logic [WIDTH:0]     sub_w;
   logic               shift_oob;
   logic [WIDTH-1:0]   alu_res;
   logic [FLAG_W-1:0]  alu_flags;
   logic [FLAG_W-1:0]  mul_flags;

   logic [WIDTH-1:0]   out_r;
   logic [FLAG_W-1:0]  flags_r;
   logic               eq_pend;

   // Handshake: the only input-to-output combinational path is out_ready -> in_ready.
   assign in_ready  = (state == S_IDLE) | ((state == S_DONE) & out_ready);
   assign out_valid = (state == S_DONE);
   assign accept    = in_valid & in_ready;
   assign is_mul    = (op == ALU_MUL);
   assign start_mul = accept & is_mul;
   assign load_alu  = accept & ~is_mul;
   assign load_mul  = (state == S_BUSY) & mul_done;

   alu_mul_seq #(
      .WIDTH (WIDTH)
   ) u_mul (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start_mul),
      .a       (inputa),
      .b       (inputb),
      .done    (mul_done),
      .product (mul_product)
   );

   // Single-cycle datapath for ops 0-6.
   always_comb begin
      add_w     = {1'b0, inputa} + {1'b0, inputb};
      sub_w     = {1'b0, inputa} - {1'b0, inputb};
      // Any set bit above the shift field means the amount is >= WIDTH.
      shift_oob = |inputb[WIDTH-1:SHW];
      alu_res   = '0;
      alu_flags = '0;
      alu_flags[FLAG_EQUAL] = (inputa == inputb);
      case (alu_op_e'(op))
         ALU_ADD: begin
            alu_res                  = add_w[WIDTH-1:0];
            alu_flags[FLAG_CARRY]    = add_w[WIDTH];
            alu_flags[FLAG_OVERFLOW] = (inputa[WIDTH-1] == inputb[WIDTH-1]) &
                                       (add_w[WIDTH-1] != inputa[WIDTH-1]);
         end
         ALU_SUB: begin
            alu_res                  = sub_w[WIDTH-1:0];
            alu_flags[FLAG_CARRY]    = sub_w[WIDTH];
            alu_flags[FLAG_OVERFLOW] = (inputa[WIDTH-1] != inputb[WIDTH-1]) &
                                       (sub_w[WIDTH-1] != inputa[WIDTH-1]);
         end
         ALU_AND: alu_res = inputa & inputb;
         ALU_OR:  alu_res = inputa | inputb;
         ALU_XOR: alu_res = inputa ^ inputb;
         ALU_SLL: alu_res = shift_oob ? '0 : (inputa << inputb[SHW-1:0]);
         ALU_SRL: alu_res = shift_oob ? '0 : (inputa >> inputb[SHW-1:0]);
         default: alu_res = '0;
      endcase
   end

   // EQUAL for a multiply was sampled at accept; CARRY flags a nonzero high half.
   always_comb begin
      mul_flags                = '0;
      mul_flags[FLAG_EQUAL]    = eq_pend;
      mul_flags[FLAG_CARRY]    = |mul_product[2*WIDTH-1:WIDTH];
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (in_valid) begin
               state_nx = is_mul ? S_BUSY : S_DONE;
            end
         end
         S_BUSY: begin
            if (mul_done) begin
               state_nx = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               if (in_valid) begin
                  state_nx = is_mul ? S_BUSY : S_DONE;
               end else begin
                  state_nx = S_IDLE;
               end
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_r   <= '0;
         flags_r <= '0;
         eq_pend <= 1'b0;
      end else begin
         if (start_mul) begin
            eq_pend <= alu_flags[FLAG_EQUAL];
         end
         if (load_alu) begin
            out_r   <= alu_res;
            flags_r <= alu_flags;
         end else if (load_mul) begin
            out_r   <= mul_product[WIDTH-1:0];
            flags_r <= mul_flags;
         end
      end
   end

   assign out      = out_r;
   assign zero     = (out_r == '0);
   assign equal    = flags_r[FLAG_EQUAL];
   assign carry    = flags_r[FLAG_CARRY];
   assign overflow = flags_r[FLAG_OVERFLOW];

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq
module tb_alu_seq;

   localparam int W = 16;

   logic          clk;
   logic          reset_n;
   logic          in_valid;
   logic          in_ready;
   logic [2:0]    op;
   logic [W-1:0]  ina;
   logic [W-1:0]  inb;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  res;
   logic          zero;
   logic          equal;
   logic          carry;
   logic          overflow;

   int checks = 0;
   int errors = 0;

   alu_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .inputa    (ina),
      .inputb    (inb),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (res),
      .zero      (zero),
      .equal     (equal),
      .carry     (carry),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference model: plain integer arithmetic on the operation's definition.
   task automatic model(input int o, input int unsigned a, input int unsigned b,
                        output int unsigned r, output bit c, output bit v);
      int      sa, sb, ss;
      longint  p;
      sa = (a >= 32768) ? int'(a) - 65536 : int'(a);
      sb = (b >= 32768) ? int'(b) - 65536 : int'(b);
      r = 0; c = 0; v = 0;
      case (o)
         0: begin r = (a + b) % 65536; c = (a + b) > 65535; ss = sa + sb; v = (ss > 32767) || (ss < -32768); end
         1: begin r = (a + 65536 - b) % 65536; c = a < b; ss = sa - sb; v = (ss > 32767) || (ss < -32768); end
         2: r = a & b;
         3: r = a | b;
         4: r = a ^ b;
         5: r = (b >= 16) ? 0 : ((a << b) % 65536);
         6: r = (b >= 16) ? 0 : (a >> b);
         default: begin p = longint'(a) * longint'(b); r = int'(p % 65536); c = (p / 65536) != 0; end
      endcase
   endtask

   task automatic check_result(input int o, input int unsigned a, input int unsigned b);
      int unsigned er;
      bit ec, ev;
      model(o, a, b, er, ec, ev);
      check("out", res, er);
      check("zero", zero, er == 0);
      check("equal", equal, a == b);
      check("carry", carry, ec);
      check("overflow", overflow, ev);
   endtask

   // One operation from IDLE: checks latency, BUSY ready-low time, result and
   // optionally a hold period with junk inputs presented.
   task automatic run_op(input int o, input logic [W-1:0] a, input logic [W-1:0] b, input int stall);
      int lat, lo;
      logic [W-1:0] held;
      @(negedge clk);
      check("idle_ready", in_ready, 1);
      check("idle_valid", out_valid, 0);
      in_valid = 1'b1; op = 3'(o); ina = a; inb = b; out_ready = (stall == 0);
      @(posedge clk);
      #1;
      in_valid = 1'b0; op = 3'($urandom); ina = W'($urandom); inb = W'($urandom);
      lat = 0; lo = 0;
      do begin
         @(negedge clk);
         lat++;
         if (!out_valid && !in_ready) lo++;
      end while (!out_valid && lat < 40);
      check("latency", lat, (o == 7) ? 17 : 1);
      check("busy_ready_low", lo, (o == 7) ? 16 : 0);
      check_result(o, a, b);
      if (stall > 0) begin
         held = res;
         in_valid = 1'b1; op = 3'd0; ina = ~a; inb = 16'h0001;
         repeat (stall) begin
            @(negedge clk);
            check("hold_out", res, held);
            check("hold_valid", out_valid, 1);
            check("hold_ready", in_ready, 0);
         end
         in_valid = 1'b0;
         out_ready = 1'b1;
      end
   endtask

   logic [2:0]   s_op [4];
   logic [W-1:0] s_a  [4];
   logic [W-1:0] s_b  [4];

   initial begin
      int seen;
      reset_n = 1'b0; in_valid = 1'b0; op = '0; ina = '0; inb = '0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_valid", out_valid, 0);
      check("rst_ready", in_ready, 1);
      check("rst_out", res, 0);
      check("rst_zero", zero, 1);
      reset_n = 1'b1;

      // Directed cases from the operation rules and boundaries.
      run_op(0, 16'h0004, 16'h0004, 0);
      run_op(1, 16'h0004, 16'h0004, 0);
      run_op(1, 16'h0003, 16'h0004, 0);
      run_op(0, 16'h7FFF, 16'h0001, 0);
      run_op(1, 16'h8000, 16'h0001, 0);
      run_op(0, 16'hFFFF, 16'h0001, 0);
      run_op(5, 16'h0001, 16'd15, 0);
      run_op(6, 16'h8000, 16'd15, 0);
      run_op(5, 16'h1234, 16'd16, 0);
      run_op(6, 16'h1234, 16'h0100, 0);
      run_op(7, 16'h0100, 16'h0101, 0);
      run_op(7, 16'h00FF, 16'h00FF, 0);
      run_op(7, 16'hFFFF, 16'hFFFF, 1);
      run_op(2, 16'hF0F0, 16'h0FF0, 5);

      // Streaming: one result per cycle with out_ready held high.
      s_op[0] = 3'd0; s_a[0] = 16'h1111; s_b[0] = 16'h2222;
      s_op[1] = 3'd4; s_a[1] = 16'hAAAA; s_b[1] = 16'hFFFF;
      s_op[2] = 3'd1; s_a[2] = 16'h0000; s_b[2] = 16'h0001;
      s_op[3] = 3'd5; s_a[3] = 16'h00F0; s_b[3] = 16'd4;
      @(negedge clk);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; op = s_op[i]; ina = s_a[i]; inb = s_b[i];
         @(negedge clk);
         check("stream_valid", out_valid, 1);
         check("stream_ready", in_ready, 1);
         check_result(int'(s_op[i]), s_a[i], s_b[i]);
      end
      in_valid = 1'b0;
      @(negedge clk);
      check("stream_drain", out_valid, 0);

      // Randomized operations with random backpressure.
      for (int n = 0; n < 60; n++) begin
         int o;
         logic [W-1:0] a, b;
         o = $urandom_range(0, 7);
         a = W'($urandom);
         if (o == 5 || o == 6) b = W'($urandom_range(0, 20));
         else if ($urandom_range(0, 3) == 0) b = a;
         else b = W'($urandom);
         run_op(o, a, b, $urandom_range(0, 2));
      end

      // Reset in the middle of a multiply.
      run_op(0, 16'h0001, 16'h0002, 0);
      @(negedge clk);
      in_valid = 1'b1; op = 3'd7; ina = 16'h0123; inb = 16'h0045; out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (8) @(negedge clk);
      check("mid_busy", in_ready, 0);
      reset_n = 1'b0;
      #1;
      check("arst_valid", out_valid, 0);
      check("arst_ready", in_ready, 1);
      check("arst_out", res, 0);
      check("arst_zero", zero, 1);
      check("arst_flags", {equal, carry, overflow}, 0);
      @(negedge clk);
      reset_n = 1'b1;
      seen = 0;
      repeat (25) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("no_stale", seen, 0);
      check("post_rst_ready", in_ready, 1);
      check("post_rst_out", res, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the 16-bit, 2-bit-opcode ALU. Widens the datapath to WIDTH bits and the opcode to 3 bits (shifts and an iterative multiply added), registers all results and flags, and adds carry/overflow flags. Uses valid/ready handshakes on both sides, so a multi-cycle operation can stall the processor datapath that sits upstream (register-file read stage) and downstream (writeback).

## Interface
- WIDTH, 16: datapath width in bits; ≥ 4, power of two.
- SHW, $clog2(WIDTH): shift-amount width (derived; do not override).
- CLK  in  1  single clock; all state updates on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- IN_VALID  in  1  OP/INPUTA/INPUTB valid this cycle.
- IN_READY  out  1  block can accept an operation this cycle.
- OP  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 MUL.
- INPUTA  in  WIDTH  operand A.
- INPUTB  in  WIDTH  operand B; the shift amount for SLL and SRL.
- OUT_VALID  out  1  OUT and the flags hold a result.
- OUT_READY  in  1  consumer takes the result this cycle.
- OUT  out  WIDTH  result.
- ZERO  out  1  OUT == 0.
- EQUAL  out  1  INPUTA == INPUTB, captured at accept (all ops).
- CARRY  out  1  ADD: carry-out. SUB: borrow (A < B unsigned). MUL: the high product half is nonzero. Otherwise 0.
- OVERFLOW  out  1  signed overflow for ADD/SUB; 0 for all other ops.

## Operation
- Accept: an operation is accepted when IN_VALID & IN_READY at a rising edge. Operands and OP are latched.
- States:
  - IDLE: no result held.
  - BUSY: MUL in progress.
  - DONE: result held.
- Transitions:
  - IDLE → DONE on accept of a non-MUL op.
  - IDLE → BUSY on accept of MUL.
  - BUSY → DONE when the iteration counter reaches WIDTH-1.
  - DONE → IDLE on OUT_READY with no new accept.
  - DONE → DONE or BUSY on OUT_READY with a simultaneous accept.
- IN_READY = (state == IDLE) | (state == DONE & OUT_READY). It is combinational, so back-to-back throughput is one op per cycle.
- OUT_VALID = (state == DONE).
- Result rules:
  - ADD/SUB are computed WIDTH+1 bits wide, and OUT is the low WIDTH bits (wraps).
  - Logic ops are bitwise.
  - SLL/SRL are logical shifts, zero-filled. INPUTB ≥ WIDTH gives OUT = 0.
  - MUL is unsigned shift-add, one partial product per cycle. OUT is the low WIDTH bits of the 2·WIDTH product.
- Hold: while OUT_VALID & !OUT_READY, OUT and all flags stay stable and new inputs are ignored.
- Reset (asynchronous): state IDLE; OUT, ZERO-source register, CARRY, OVERFLOW, EQUAL and the MUL counter all clear to 0. As a consequence, during reset OUT_VALID=0, IN_READY=1, OUT=0 and ZERO=1.
- Reset during BUSY aborts the multiply. No result is produced.

## Timing
- Latency, accept edge to OUT_VALID: 1 cycle for ops 0–6; WIDTH+1 cycles for MUL (17 at WIDTH=16).
- IN_READY is low throughout BUSY, and in DONE while OUT_READY is low.
- EQUAL, CARRY and OVERFLOW are registered together with OUT and change only when DONE is entered.
- ZERO is decoded from the OUT register, so it is coherent with OUT in the same cycle.
- There are no combinational paths from operands to outputs. The only combinational path from an input to an output is OUT_READY → IN_READY.

## Structure
- Package alu_seq_pkg:
  - op enum (ALU_ADD … ALU_MUL, 3 bits);
  - state enum (S_IDLE, S_BUSY, S_DONE);
  - shared flag-bit constants.
- Sub-module alu_mul_seq holds the iterative multiplier:
  - ports: start, the operands, done, product;
  - contents: the counter, accumulator and shifted multiplicand.
- The top level holds the FSM, single-cycle datapath, result/flag registers and handshake.

## Test plan
- Reset, then ADD 0x0004+0x0004 with OUT_READY=1: OUT_VALID 1 cycle after accept, OUT=0x0008, EQUAL=1, ZERO=0, CARRY=0.
- SUB 0x0004−0x0004: OUT=0x0000, ZERO=1. Then SUB 0x0003−0x0004: OUT=0xFFFF, CARRY=1, OVERFLOW=0. Then ADD 0x7FFF+0x0001: OUT=0x8000, OVERFLOW=1.
- Shift boundaries:
  - SLL 0x0001 by 15 → 0x8000.
  - SRL 0x8000 by 15 → 0x0001.
  - SLL 0x1234 by 16 → 0x0000, ZERO=1.
- MUL 0x0100×0x0101:
  - IN_READY low for 16 cycles;
  - OUT_VALID 17 cycles after accept;
  - OUT=0x0100, CARRY=1 (product 0x0001_0100).
  - Also MUL 0x00FF×0x00FF: OUT=0xFE01, CARRY=0.
- Backpressure and throughput:
  - Hold OUT_READY=0 for 5 cycles after AND 0xF0F0&0x0FF0: OUT stays 0x00F0, IN_READY=0, and a new IN_VALID is not accepted.
  - Streaming four ops with OUT_READY=1 gives 1 result per cycle.
- Pull RESET_N low mid-MUL (cycle 8):
  - outputs clear immediately;
  - after release, OUT_VALID=0 and IN_READY=1;
  - no stale product appears.
